// File: rtl/axi_burst_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : axi_burst_sched_pkg
//  Purpose : Shared types and helpers for the AXI burst scheduler. Provides
//            the scheduler state encoding, the AXI length width and the
//            round-robin successor function used by the arbiter.
//  Config  : none (AXI_BURST_SCHED_TRUNC_EN only affects axi_burst_sched)
//  Revision: 1.0  initial release
// ============================================================================
package axi_burst_sched_pkg;

    // AXI-coded burst length (beats - 1) is always one byte wide.
    localparam int AXI_LEN_W = 8;

    // Channel index width; CH_NUM is limited to 1..8.
    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_REQ  = 3'd2,
        ST_BUSY = 3'd3,
        ST_UPD  = 3'd4
    } state_t;

    // Channel that follows idx in a ring of n channels.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                                 input int unsigned      n);
        if ((32'(idx) + 32'd1) >= n) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_sched_if.sv
`default_nettype none
// ============================================================================
//  Module  : axi_burst_sched_if
//  Purpose : Handshake bundle between the burst scheduler and the AXI master
//            engine plus the data-path channel select.
//  Signals : axi_ready  master idle            (engine -> scheduler)
//            axi_done   burst complete pulse   (engine -> scheduler)
//            axi_start  burst request          (scheduler -> engine)
//            axi_addr   burst start address    (scheduler -> engine)
//            axi_len    AXI-coded length       (scheduler -> engine)
//            grant      one-hot channel select (scheduler -> data path)
//  Modports: master = scheduler side, slave = AXI engine side
//  Config  : none
//  Revision: 1.0  initial release
// ============================================================================
interface axi_burst_sched_if #(
    parameter int CH_NUM = 4,
    parameter int ADDR_W = 30
) ();

    logic              axi_ready;
    logic              axi_done;
    logic              axi_start;
    logic [ADDR_W-1:0] axi_addr;
    logic [7:0]        axi_len;
    logic [CH_NUM-1:0] grant;

    modport master (
        input  axi_ready,
        input  axi_done,
        output axi_start,
        output axi_addr,
        output axi_len,
        output grant
    );

    modport slave (
        output axi_ready,
        output axi_done,
        input  axi_start,
        input  axi_addr,
        input  axi_len,
        input  grant
    );

endinterface
`default_nettype wire

// File: rtl/axi_burst_sched_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arb
//  Purpose : Single-cycle round-robin arbiter. The search starts at the
//            channel after last_grant and wraps once around the ring.
//  Ports   : req        [N]      request vector
//            last_grant [IDX_W]  index of the previously granted channel
//            grant      [N]      one-hot winner (all zero if no request)
//  Config  : none
//  Revision: 1.0  initial release
// ============================================================================
module rr_arb
    import axi_burst_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  wire  [N-1:0]     req,
    input  wire  [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant
);

    generate
        if (N == 1) begin : g_single
            // Only one requester: priority history is irrelevant.
            logic w_unused_last;
            assign w_unused_last = ^last_grant;
            assign grant         = req;
        end else begin : g_multi
            logic             found;
            logic [IDX_W-1:0] cand;

            always_comb begin
                grant = '0;
                found = 1'b0;
                cand  = rr_next(last_grant, N);
                for (int k = 0; k < N; k++) begin
                    for (int i = 0; i < N; i++) begin
                        if (!found && (int'(cand) == i) && req[i]) begin
                            grant[i] = 1'b1;
                            found    = 1'b1;
                        end
                    end
                    cand = rr_next(cand, N);
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/axi_burst_sched.sv
`default_nettype none
// ============================================================================
//  Module  : axi_burst_sched
//  Purpose : Shares one AXI master between CH_NUM FIFO channels. Each channel
//            owns a circular address window; when its FIFO holds (write) or
//            can accept (read) a full burst it becomes eligible, a
//            round-robin arbiter picks one, the burst is issued and the
//            channel pointer advances (wrapping at the window end).
//  Ports   : clk, rst_n             clock, asynchronous active-low reset
//            ch_rst   [CH_NUM]        per-channel pointer reset
//            ch_en    [CH_NUM]        channel enable
//            ch_beg_addr/ch_end_addr  packed inclusive windows
//            ch_burst_len             packed AXI-coded lengths
//            ch_fifo_cnt              packed FIFO levels
//            bus (master modport)     axi_ready/done in, axi_start/addr/len
//                                     and grant out
//  Config  : AXI_BURST_SCHED_TRUNC_EN - shorten the burst that would run past
//            the window end instead of wrapping before it.
//  Revision: 1.0  initial release
// ============================================================================
module axi_burst_sched
    import axi_burst_sched_pkg::*;
#(
    parameter int CH_NUM     = 4,
    parameter int DIR        = 0,
    parameter int ADDR_W     = 30,
    parameter int CNT_W      = 10,
    parameter int FIFO_DEPTH = 512,
    parameter int BEAT_BYTES = 8
) (
    input  wire                       clk,
    input  wire                       rst_n,
    input  wire  [CH_NUM-1:0]         ch_rst,
    input  wire  [CH_NUM-1:0]         ch_en,
    input  wire  [CH_NUM*ADDR_W-1:0]  ch_beg_addr,
    input  wire  [CH_NUM*ADDR_W-1:0]  ch_end_addr,
    input  wire  [CH_NUM*8-1:0]       ch_burst_len,
    input  wire  [CH_NUM*CNT_W-1:0]   ch_fifo_cnt,
    axi_burst_sched_if.master         bus
);

    localparam int SUM_W = CNT_W + 1;
    localparam int SHIFT = $clog2(BEAT_BYTES);
    localparam int EW    = ADDR_W + 2;   // headroom for next + burst bytes

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic                   start_q, start_d;
    logic [CH_NUM-1:0]      grant_q, grant_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [AXI_LEN_W-1:0]   len_q, len_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic                   init_q;
    logic [ADDR_W-1:0]      ptr_q [CH_NUM];
    logic [ADDR_W-1:0]      ptr_d [CH_NUM];
    logic [CH_NUM-1:0]      pend_q, pend_d;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]      w_beg     [CH_NUM];
    logic [ADDR_W-1:0]      w_end     [CH_NUM];
    logic [AXI_LEN_W-1:0]   w_blen    [CH_NUM];
    logic [CNT_W-1:0]       w_cnt     [CH_NUM];
    logic [AXI_LEN_W-1:0]   w_eff_len [CH_NUM];
    logic [CH_NUM-1:0]      w_elig;
    logic [CH_NUM-1:0]      w_arb_grant;
    logic [CH_NUM-1:0]      w_wrap;
    logic [IDX_W-1:0]       w_sel_idx;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [AXI_LEN_W-1:0]   w_sel_len;
    logic [EW-1:0]          w_burst_bytes;
    logic [EW-1:0]          w_next;
    logic                   w_upd;

    // Byte size of the burst in flight and the address right after it.
    assign w_burst_bytes = (EW'(len_q) + EW'(1)) << SHIFT;
    assign w_next        = EW'(addr_q) + w_burst_bytes;

    generate
        for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
            logic [SUM_W-1:0] w_need;

            assign w_beg[i]  = ch_beg_addr[i*ADDR_W +: ADDR_W];
            assign w_end[i]  = ch_end_addr[i*ADDR_W +: ADDR_W];
            assign w_blen[i] = ch_burst_len[i*8 +: 8];
            assign w_cnt[i]  = ch_fifo_cnt[i*CNT_W +: CNT_W];

`ifdef AXI_BURST_SCHED_TRUNC_EN
            // Bytes left up to the inclusive window end; a shorter tail
            // burst is issued when a full one would not fit.
            logic [ADDR_W:0] w_remain;
            logic [ADDR_W:0] w_full;

            assign w_remain     = {1'b0, w_end[i]} + (ADDR_W+1)'(1) - {1'b0, ptr_q[i]};
            assign w_full       = ((ADDR_W+1)'(w_blen[i]) + (ADDR_W+1)'(1)) << SHIFT;
            assign w_eff_len[i] = (w_remain < w_full)
                                ? AXI_LEN_W'((w_remain >> SHIFT) - (ADDR_W+1)'(1))
                                : w_blen[i];
            // A tail burst may end exactly at the window end, so only wrap
            // once the pointer has moved past it.
            assign w_wrap[i]    = w_next > EW'(w_end[i]);
`else
            assign w_eff_len[i] = w_blen[i];
            // Wrap early when the following full burst would cross the end.
            assign w_wrap[i]    = (w_next + w_burst_bytes) > (EW'(w_end[i]) + EW'(1));
`endif

            assign w_need = SUM_W'(w_eff_len[i]) + SUM_W'(1);

            if (DIR == 0) begin : g_wr
                // Write: FIFO must already hold the whole burst.
                assign w_elig[i] = ch_en[i] & ~ch_rst[i] & (SUM_W'(w_cnt[i]) >= w_need);
            end else begin : g_rd
                // Read: FIFO must have room for the whole burst.
                assign w_elig[i] = ch_en[i] & ~ch_rst[i]
                                 & ((SUM_W'(w_cnt[i]) + w_need) <= SUM_W'(FIFO_DEPTH));
            end
        end
    endgenerate

    rr_arb #(
        .N (CH_NUM)
    ) u_rr_arb (
        .req        (w_elig),
        .last_grant (rr_q),
        .grant      (w_arb_grant)
    );

    // Winner's index, pointer and length.
    always_comb begin
        w_sel_idx  = '0;
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (w_arb_grant[i]) begin
                w_sel_idx  = IDX_W'(i);
                w_sel_addr = ptr_q[i];
                w_sel_len  = w_eff_len[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scheduler FSM: next state and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        len_d   = len_q;
        rr_d    = rr_q;
        w_upd   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Pointers are loaded on the first clock after reset; hold
                // off until they are valid.
                if (!init_q && (|w_elig) && bus.axi_ready) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if ((|w_arb_grant) && bus.axi_ready) begin
                    state_d = ST_REQ;
                    start_d = 1'b1;
                    grant_d = w_arb_grant;
                    addr_d  = w_sel_addr;
                    len_d   = w_sel_len;
                    rr_d    = w_sel_idx;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // The engine signals acceptance by dropping axi_ready.
                if (!bus.axi_ready) begin
                    start_d = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.axi_done) begin
                    state_d = ST_UPD;
                end
            end
            ST_UPD: begin
                w_upd   = 1'b1;
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                start_d = 1'b0;
                grant_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-channel address pointers
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            ptr_d[i]  = ptr_q[i];
            pend_d[i] = pend_q[i];
            if (init_q) begin
                ptr_d[i]  = w_beg[i];
                pend_d[i] = 1'b0;
            end else if (ch_rst[i]) begin
                ptr_d[i]  = w_beg[i];
                // A reset during the channel's own burst must survive until
                // the update, otherwise the post-burst advance would undo it.
                pend_d[i] = grant_q[i] & ~w_upd;
            end else if (w_upd && grant_q[i]) begin
                ptr_d[i]  = (pend_q[i] || w_wrap[i]) ? w_beg[i] : w_next[ADDR_W-1:0];
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            grant_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            rr_q    <= IDX_W'(CH_NUM - 1);
            init_q  <= 1'b1;
            pend_q  <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            rr_q    <= rr_d;
            init_q  <= 1'b0;
            pend_q  <= pend_d;
            for (int i = 0; i < CH_NUM; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
        end
    end

    assign bus.axi_start = start_q;
    assign bus.axi_addr  = addr_q;
    assign bus.axi_len   = len_q;
    assign bus.grant     = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_sched.sv
`default_nettype none
// ============================================================================
//  Module  : tb_axi_burst_sched
//  Purpose : Self-checking bench for axi_burst_sched. Instance A is a 4-channel
//            write scheduler driven by a small AXI engine model; instance B is
//            a single-channel read scheduler used for the FIFO-room boundary.
//  Config  : AXI_BURST_SCHED_TRUNC_EN selects the tail-burst expectations.
//  Revision: 1.0  initial release
// ============================================================================
module tb_axi_burst_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  ch_rst_a, ch_en_a;
    logic [119:0] beg_v, end_v;
    logic [31:0] blen_v;
    logic [39:0] cnt_v;
    logic        ch_rst_b, ch_en_b;
    logic [29:0] beg_b, end_b;
    logic [7:0]  blen_b;
    logic [9:0]  cnt_b;

    axi_burst_sched_if #(.CH_NUM(4), .ADDR_W(30)) bus_a ();
    axi_burst_sched_if #(.CH_NUM(1), .ADDR_W(30)) bus_b ();

    axi_burst_sched #(
        .CH_NUM(4), .DIR(0), .ADDR_W(30), .CNT_W(10), .FIFO_DEPTH(512), .BEAT_BYTES(8)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ch_rst(ch_rst_a), .ch_en(ch_en_a),
        .ch_beg_addr(beg_v), .ch_end_addr(end_v), .ch_burst_len(blen_v),
        .ch_fifo_cnt(cnt_v), .bus(bus_a.master)
    );

    axi_burst_sched #(
        .CH_NUM(1), .DIR(1), .ADDR_W(30), .CNT_W(10), .FIFO_DEPTH(512), .BEAT_BYTES(8)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ch_rst(ch_rst_b), .ch_en(ch_en_b),
        .ch_beg_addr(beg_b), .ch_end_addr(end_b), .ch_burst_len(blen_b),
        .ch_fifo_cnt(cnt_b), .bus(bus_b.master)
    );

    int checks   = 0;
    int failures = 0;
    int pops     = 0;

    typedef struct {
        int          ch;
        logic [29:0] addr;
        logic [7:0]  len;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_burst(input int ch, input logic [29:0] addr, input logic [7:0] len);
        exp_t e;
        e.ch   = ch;
        e.addr = addr;
        e.len  = len;
        sb.push_back(e);
    endtask

    task automatic wait_pops(input int target, input string name);
        int c = 0;
        while (pops < target && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (pops < target) begin
            checks++;
            failures++;
            $display("FAIL %s timeout bursts=%0d required=%0d", name, pops, target);
        end
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (!(bus_a.grant == 4'd0 && bus_a.axi_ready && !bus_a.axi_start) && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) begin
            checks++;
            failures++;
            $display("FAIL %s idle timeout grant=0x%0h required=0x0", name, bus_a.grant);
        end
        repeat (3) @(negedge clk);
    endtask

    // AXI engine model for instance A: accepts a request, runs a short burst,
    // pulses done and returns to ready.
    initial begin
        bus_a.axi_ready = 1'b1;
        bus_a.axi_done  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_a.axi_start && bus_a.axi_ready) begin
                bus_a.axi_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                bus_a.axi_done = 1'b1;
                @(posedge clk);
                #1;
                bus_a.axi_done  = 1'b0;
                bus_a.axi_ready = 1'b1;
            end
        end
    end

    // Scoreboard monitor: every new request of instance A is matched against
    // the oldest expected burst.
    logic prev_start = 1'b0;
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (bus_a.axi_start && !prev_start) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start addr=0x%0h grant=0x%0h required=no request",
                             bus_a.axi_addr, bus_a.grant);
                end else begin
                    mon_e = sb.pop_front();
                    check("burst_grant", 64'(bus_a.grant), 64'(1) << mon_e.ch);
                    check("burst_addr",  64'(bus_a.axi_addr), 64'(mon_e.addr));
                    check("burst_len",   64'(bus_a.axi_len), 64'(mon_e.len));
                    pops++;
                end
            end
            prev_start = bus_a.axi_start;
        end
    end

    int base;

    initial begin
        rst_n    = 1'b0;
        ch_rst_a = 4'd0;
        ch_en_a  = 4'd0;
        cnt_v    = {4{10'd20}};
        blen_v   = {4{8'd15}};
        beg_v    = {30'd0,   30'h2000, 30'h1000, 30'd0};
        end_v    = {30'd999, 30'h23FF, 30'h13FF, 30'd1023};
        ch_rst_b = 1'b0;
        ch_en_b  = 1'b1;
        beg_b    = 30'h400;
        end_b    = 30'h7FF;
        blen_b   = 8'd15;
        cnt_b    = 10'd497;
        bus_b.axi_ready = 1'b1;
        bus_b.axi_done  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_start",   64'(bus_a.axi_start), 64'd0);
        check("rst_grant",   64'(bus_a.grant), 64'd0);
        check("rst_len",     64'(bus_a.axi_len), 64'd0);
        check("rst_addr",    64'(bus_a.axi_addr), 64'd0);
        check("rst_b_start", 64'(bus_b.axi_start), 64'd0);
        rst_n = 1'b1;

        // Read direction: 497 + 16 beats exceeds 512, 496 + 16 fits.
        repeat (8) @(negedge clk);
        check("rd_cnt497_no_start", 64'(bus_b.axi_start), 64'd0);
        cnt_b = 10'd496;
        @(posedge clk); #1;
        check("rd_start_after_1", 64'(bus_b.axi_start), 64'd0);
        @(posedge clk); #1;
        check("rd_start_after_2", 64'(bus_b.axi_start), 64'd1);
        check("rd_addr",  64'(bus_b.axi_addr), 64'h400);
        check("rd_len",   64'(bus_b.axi_len), 64'd15);
        check("rd_grant", 64'(bus_b.grant), 64'd1);

        // Round robin over all four channels, then revisit channel 0.
        @(negedge clk);
        base = pops;
        expect_burst(0, 30'd0, 8'd15);
        expect_burst(1, 30'h1000, 8'd15);
        expect_burst(2, 30'h2000, 8'd15);
        expect_burst(3, 30'd0, 8'd15);
        expect_burst(0, 30'd128, 8'd15);
        ch_en_a = 4'hF;
        wait_pops(base + 5, "rr_order");
        ch_en_a = 4'h0;
        wait_idle("rr_order");

        // Full window walk on channel 0 after a pointer reset.
        ch_rst_a = 4'b0001;
        @(negedge clk);
        ch_rst_a = 4'b0000;
        base = pops;
        for (int k = 0; k < 8; k++) expect_burst(0, 30'(k * 128), 8'd15);
        expect_burst(0, 30'd0, 8'd15);
        ch_en_a = 4'b0001;
        wait_pops(base + 9, "window_walk");
        ch_en_a = 4'h0;
        wait_idle("window_walk");

        // Pointer reset while channel 1 is mid-burst.
        base = pops;
        expect_burst(1, 30'h1080, 8'd15);
        expect_burst(1, 30'h1000, 8'd15);
        ch_en_a = 4'b0010;
        wait_pops(base + 1, "midburst_first");
        @(negedge clk);
        check("midburst_busy", 64'(bus_a.axi_ready), 64'd0);
        ch_rst_a = 4'b0010;
        @(negedge clk);
        ch_rst_a = 4'b0000;
        wait_pops(base + 2, "midburst_rst");
        ch_en_a = 4'h0;
        wait_idle("midburst_rst");

        // Write-side level boundary on channel 2: 15 beats < 16 needed.
        cnt_v[20 +: 10] = 10'd15;
        ch_en_a = 4'b0100;
        base = pops;
        repeat (12) @(negedge clk);
        check("wr_cnt15_no_burst", 64'(pops), 64'(base));
        check("wr_cnt15_no_start", 64'(bus_a.axi_start), 64'd0);
        expect_burst(2, 30'h2080, 8'd15);
        cnt_v[20 +: 10] = 10'd16;
        @(posedge clk); #1;
        check("wr_start_after_1", 64'(bus_a.axi_start), 64'd0);
        @(posedge clk); #1;
        check("wr_start_after_2", 64'(bus_a.axi_start), 64'd1);
        wait_pops(base + 1, "wr_cnt16");
        ch_en_a = 4'h0;
        cnt_v[20 +: 10] = 10'd20;
        wait_idle("wr_cnt16");

        // Channel 3 window 0..999: the last 104 bytes do not hold a full burst.
        ch_rst_a = 4'b1000;
        @(negedge clk);
        ch_rst_a = 4'b0000;
        base = pops;
        for (int k = 0; k < 7; k++) expect_burst(3, 30'(k * 128), 8'd15);
`ifdef AXI_BURST_SCHED_TRUNC_EN
        expect_burst(3, 30'd896, 8'd12);
        expect_burst(3, 30'd0, 8'd15);
        ch_en_a = 4'b1000;
        wait_pops(base + 9, "window_tail");
`else
        expect_burst(3, 30'd0, 8'd15);
        ch_en_a = 4'b1000;
        wait_pops(base + 8, "window_tail");
`endif
        ch_en_a = 4'h0;
        wait_idle("window_tail");

        // Reset asserted while channel 2 is busy.
        base = pops;
        expect_burst(2, 30'h2100, 8'd15);
        ch_en_a = 4'b0100;
        wait_pops(base + 1, "busy_reset_first");
        ch_en_a = 4'h0;
        @(posedge clk);
        @(negedge clk);
        check("busy_grant", 64'(bus_a.grant), 64'h4);
        rst_n = 1'b0;
        #1;
        check("busy_rst_start", 64'(bus_a.axi_start), 64'd0);
        check("busy_rst_grant", 64'(bus_a.grant), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = pops;
        expect_burst(0, 30'd0, 8'd15);
        expect_burst(1, 30'h1000, 8'd15);
        ch_en_a = 4'hF;
        wait_pops(base + 2, "after_reset");
        ch_en_a = 4'h0;
        wait_idle("after_reset");

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
